// File: rtl/l2c_xout_sched_pkg.sv
`default_nettype none
//==============================================================================
// Module      : l2c_xout_sched_pkg
// Description : Shared widths, XU command encoding, scheduler state encoding
//               and flattened-bus slice helper for the L2C XU output scheduler.
// Revision    : 1.0 - initial release
//==============================================================================

// Select channel <idx> out of a flattened bus of <w>-bit fields.
`ifndef L2C_SLICE
`define L2C_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package l2c_xout_sched_pkg;

    localparam int XU_L2C_CMD_W   = 4;
    localparam logic [XU_L2C_CMD_W-1:0] XU_L2C_CMD_NO = '0;

    localparam int CORE_ADDR_W    = 32;
    localparam int CORE_UID_W     = 8;
    localparam int CPU_TILE_ID_W  = 4;
    localparam int CORE_DATA_W    = 64;
    localparam int CORE_DATA_BE_W = CORE_DATA_W / 8;

    localparam int XOUT_TMO_CYC_DFLT = 1024;

    typedef enum logic [0:0] {
        XOUT_ST_IDLE = 1'b0,
        XOUT_ST_HOLD = 1'b1
    } xout_st_e;

endpackage

`default_nettype wire

// File: rtl/l2c_xout_sched_arb.sv
`default_nettype none
//==============================================================================
// Module      : arb_nch_rr_pick
// Description : Combinational round-robin picker. Returns the first set request
//               at or after (rr_ptr+1) mod CH_NUM, wrapping around.
// Revision    : 1.0 - initial release
//==============================================================================
module arb_nch_rr_pick #(
    parameter int CH_NUM  = 4,
    parameter int CH_ID_W = 2
) (
    input  logic [CH_NUM-1:0]  req_vec,
    input  logic [CH_ID_W-1:0] rr_ptr,
    output logic               vld,
    output logic [CH_ID_W-1:0] idx
);

    int w_best;
    int w_off;

    // Pick the requester with the smallest rotated distance from rr_ptr+1.
    always_comb begin
        w_best = CH_NUM;
        w_off  = 0;
        vld    = 1'b0;
        idx    = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            w_off = (j + CH_NUM - 1 - int'(rr_ptr)) % CH_NUM;
            if (req_vec[j] && (w_off < w_best)) begin
                w_best = w_off;
                vld    = 1'b1;
                idx    = CH_ID_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2c_xout_sched.sv
`default_nettype none
//==============================================================================
// Module      : l2c_xout_sched
// Description : N-channel, transaction-locked round-robin scheduler for the L2C
//               XU output port. Registered payload held until XU ack, with an
//               ack watchdog for debug.
// Revision    : 1.0 - initial release
//==============================================================================
module l2c_xout_sched
    import l2c_xout_sched_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CH_ID_W = 2,
    parameter int TMO_CYC = XOUT_TMO_CYC_DFLT,
    parameter int TMO_W   = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CH_NUM-1:0]                   in_req,
    input  logic [CH_NUM*XU_L2C_CMD_W-1:0]      in_cmd,
    input  logic [CH_NUM*CORE_ADDR_W-1:0]       in_addr,
    input  logic [CH_NUM*CORE_UID_W-1:0]        in_uid,
    input  logic [CH_NUM*CPU_TILE_ID_W-1:0]     in_src,
    input  logic [CH_NUM*CORE_DATA_BE_W-1:0]    in_data_be,
    input  logic [CH_NUM*CORE_DATA_W-1:0]       in_data,
    output logic [CH_NUM-1:0]                   in_ack,
    output logic                                req,
    output logic [XU_L2C_CMD_W-1:0]             cmd,
    output logic [CORE_ADDR_W-1:0]              addr,
    output logic [CORE_UID_W-1:0]               uid,
    output logic [CPU_TILE_ID_W-1:0]            src,
    output logic [CORE_DATA_BE_W-1:0]           data_be,
    output logic [CORE_DATA_W-1:0]              data,
    input  logic                                ack,
    output logic                                busy,
    output logic [CH_ID_W-1:0]                  gnt_id,
    output logic                                tmo_err,
    output logic [CH_ID_W-1:0]                  tmo_ch
);

    localparam logic             c_tmo_en   = (TMO_CYC > 0);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
    localparam logic [TMO_W-1:0] c_tmo_sat  = TMO_W'(TMO_CYC);

    xout_st_e                   r_state;
    xout_st_e                   w_state_nxt;
    logic                       w_capture;
    logic                       w_done;
    logic                       w_busy;
    logic                       w_tmo;
    logic                       w_pick_vld;
    logic [CH_ID_W-1:0]         w_pick_idx;

    logic                       r_req;
    logic [XU_L2C_CMD_W-1:0]    r_cmd;
    logic [CORE_ADDR_W-1:0]     r_addr;
    logic [CORE_UID_W-1:0]      r_uid;
    logic [CPU_TILE_ID_W-1:0]   r_src;
    logic [CORE_DATA_BE_W-1:0]  r_data_be;
    logic [CORE_DATA_W-1:0]     r_data;
    logic [CH_ID_W-1:0]         r_gnt_id;
    logic [CH_ID_W-1:0]         r_rr_ptr;
    logic [CH_ID_W-1:0]         r_tmo_ch;
    logic [TMO_W-1:0]           r_tmo_cnt;

    // Per-channel views of the flattened payload buses.
    logic [XU_L2C_CMD_W-1:0]    w_cmd_a     [CH_NUM];
    logic [CORE_ADDR_W-1:0]     w_addr_a    [CH_NUM];
    logic [CORE_UID_W-1:0]      w_uid_a     [CH_NUM];
    logic [CPU_TILE_ID_W-1:0]   w_src_a     [CH_NUM];
    logic [CORE_DATA_BE_W-1:0]  w_data_be_a [CH_NUM];
    logic [CORE_DATA_W-1:0]     w_data_a    [CH_NUM];

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_unpack
        assign w_cmd_a[gi]     = `L2C_SLICE(in_cmd,     gi, XU_L2C_CMD_W);
        assign w_addr_a[gi]    = `L2C_SLICE(in_addr,    gi, CORE_ADDR_W);
        assign w_uid_a[gi]     = `L2C_SLICE(in_uid,     gi, CORE_UID_W);
        assign w_src_a[gi]     = `L2C_SLICE(in_src,     gi, CPU_TILE_ID_W);
        assign w_data_be_a[gi] = `L2C_SLICE(in_data_be, gi, CORE_DATA_BE_W);
        assign w_data_a[gi]    = `L2C_SLICE(in_data,    gi, CORE_DATA_W);
    end

    arb_nch_rr_pick #(
        .CH_NUM  (CH_NUM),
        .CH_ID_W (CH_ID_W)
    ) u_pick (
        .req_vec (in_req),
        .rr_ptr  (r_rr_ptr),
        .vld     (w_pick_vld),
        .idx     (w_pick_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= XOUT_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: grant in IDLE, release in HOLD on ack only.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            XOUT_ST_IDLE: begin
                if (w_pick_vld) begin
                    w_capture   = 1'b1;
                    w_state_nxt = XOUT_ST_HOLD;
                end
            end
            XOUT_ST_HOLD: begin
                if (ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = XOUT_ST_IDLE;
                end
            end
            default: w_state_nxt = XOUT_ST_IDLE;
        endcase
    end

    assign w_busy = (r_state == XOUT_ST_HOLD);
    assign w_tmo  = c_tmo_en & w_busy & ~ack & (r_tmo_cnt == c_tmo_last);

    // Capture the winner's payload; clear req/cmd when XU acknowledges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_cmd     <= XU_L2C_CMD_NO;
            r_addr    <= '0;
            r_uid     <= '0;
            r_src     <= '0;
            r_data_be <= '0;
            r_data    <= '0;
            r_gnt_id  <= '0;
            r_rr_ptr  <= CH_ID_W'(CH_NUM - 1);
        end else if (w_capture) begin
            r_req     <= 1'b1;
            r_cmd     <= w_cmd_a[w_pick_idx];
            r_addr    <= w_addr_a[w_pick_idx];
            r_uid     <= w_uid_a[w_pick_idx];
            r_src     <= w_src_a[w_pick_idx];
            r_data_be <= w_data_be_a[w_pick_idx];
            r_data    <= w_data_a[w_pick_idx];
            r_gnt_id  <= w_pick_idx;
        end else if (w_done) begin
            r_req     <= 1'b0;
            r_cmd     <= XU_L2C_CMD_NO;
            r_rr_ptr  <= r_gnt_id;
        end
    end

    // Ack watchdog: counts unacked HOLD cycles, saturating so it fires once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_tmo_ch  <= '0;
        end else begin
            if (w_capture) begin
                r_tmo_cnt <= '0;
            end else if (w_busy && !ack && (r_tmo_cnt != c_tmo_sat)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo) begin
                r_tmo_ch <= r_gnt_id;
            end
        end
    end

    // Ack is passed straight back to the channel owning the port.
    always_comb begin
        in_ack = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            in_ack[j] = w_busy & ack & (r_gnt_id == CH_ID_W'(j));
        end
    end

    assign req     = r_req;
    assign cmd     = r_cmd;
    assign addr    = r_addr;
    assign uid     = r_uid;
    assign src     = r_src;
    assign data_be = r_data_be;
    assign data    = r_data;
    assign busy    = w_busy;
    assign gnt_id  = r_gnt_id;
    assign tmo_err = w_tmo;
    assign tmo_ch  = r_tmo_ch;

endmodule

`default_nettype wire
